fetch_buffer: RTL and testbench

//  Decoupling queue directly downstream of the IF (PC) stage. Pairs each fetch PC with the

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_buffer.sv | 62 ++++++
 tb/tb_fetch_buffer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
package cpu_pkg;
   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [XLEN-1:0]    RESET_PC_VAL = 32'h4000_0000;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry in-order storage with wrapping pointers, occupancy count and sync flush.
module fetch_fifo #(
   parameter  int W     = 64,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           wr_en,
   input  logic [W-1:0]   wr_data,
   input  logic           rd_en,
   output logic [W-1:0]   rd_data,
   output logic [PTR_W:0] count
);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;

   // Storage is not reset; rd_data is masked to zero while empty instead.
   always_ff @(posedge clk)
      if (wr_en && !flush) mem[wr_ptr_q] <= wr_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign count   = count_q;
   assign rd_data = (count_q != '0) ? mem[rd_ptr_q] : '0;

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(wr_en && !rd_en && count_q == CNT_FULL));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(rd_en && count_q == '0));
`endif
endmodule

// File: rtl/fetch_buffer.sv
// Pairs each accepted fetch PC with next-cycle imem data and queues the result toward ID.
module fetch_buffer
   import cpu_pkg::*;
#(
   parameter  int AWIDTH = XLEN,
   parameter  int DWIDTH = INSTR_W,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_in,
   input  logic [AWIDTH-1:0] pc_in,
   output logic              stall_out,
   input  logic [DWIDTH-1:0] imem_rdata_in,
   input  logic              flush_in,
   output logic              id_valid_out,
   input  logic              id_ready_in,
   output logic [AWIDTH-1:0] id_pc_out,
   output logic [DWIDTH-1:0] id_instr_out
);
   localparam int W = AWIDTH + DWIDTH;

   logic              inflight_q;
   logic [AWIDTH-1:0] pc_q;
   logic              acc, enq, deq;
   logic [PTR_W:0]    count;
   logic [PTR_W+1:0]  occ;
   logic [W-1:0]      head;

   // Occupancy counts the outstanding imem response so an enqueue never meets a full queue.
   assign occ          = {1'b0, count} + (PTR_W+2)'(inflight_q);
   assign stall_out    = occ >= (PTR_W+2)'(DEPTH);
   assign acc          = req_valid_in & ~stall_out & ~flush_in;
   assign enq          = inflight_q & ~flush_in;
   assign id_valid_out = (count != '0) & ~flush_in;
   assign deq          = id_valid_out & id_ready_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         pc_q       <= '0;
      end else begin
         inflight_q <= acc;
         if (acc) pc_q <= pc_in;
      end
   end

   fetch_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush_in),
      .wr_en   (enq),
      .wr_data ({pc_q, imem_rdata_in}),
      .rd_en   (deq),
      .rd_data (head),
      .count   (count)
   );

   assign id_pc_out    = head[W-1:DWIDTH];
   assign id_instr_out = head[DWIDTH-1:0];
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: vector table, directed corner cases, random traffic vs a queue model.
module tb_fetch_buffer;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid_in = 1'b0;
   logic [31:0] pc_in = '0;
   logic        stall_out;
   logic [31:0] imem_rdata_in = '0;
   logic        flush_in = 1'b0;
   logic        id_valid_out;
   logic        id_ready_in = 1'b0;
   logic [31:0] id_pc_out;
   logic [31:0] id_instr_out;

   fetch_buffer #(.AWIDTH(32), .DWIDTH(32), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid_in(req_valid_in), .pc_in(pc_in),
      .stall_out(stall_out), .imem_rdata_in(imem_rdata_in), .flush_in(flush_in),
      .id_valid_out(id_valid_out), .id_ready_in(id_ready_in),
      .id_pc_out(id_pc_out), .id_instr_out(id_instr_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          req;
      logic [31:0] pc;
      bit          rdy;
      bit          ev;
      bit          es;
      logic [31:0] epc;
   } vec_t;

   int total = 0;
   int bad   = 0;

   // reference model: queue of {pc, instr} plus the single outstanding request
   logic [63:0] mq[$];
   bit          minf;
   logic [31:0] mpc;
   logic [31:0] prev_pc;

   bit          tv_on;
   vec_t        cur;
   bit          s_v, s_st;
   logic [31:0] s_pc, s_in;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return 32'h13 + (a - RESET_PC_VAL);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Called at a negedge: drive one cycle, check outputs, advance the model on the posedge.
   task automatic step(input bit req, input logic [31:0] pc, input bit fl, input bit rdy);
      bit e_v, e_st, deq, acc, enq;
      logic [31:0] e_pc, e_in;
      req_valid_in  = req;
      pc_in         = pc;
      flush_in      = fl;
      id_ready_in   = rdy;
      imem_rdata_in = imem(prev_pc);
      #1;
      e_v  = (mq.size() != 0) && !fl;
      e_pc = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
      e_in = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
      e_st = (mq.size() + int'(minf)) >= 4;
      chk("valid", 64'(id_valid_out), 64'(e_v));
      chk("stall", 64'(stall_out), 64'(e_st));
      chk("pc", 64'(id_pc_out), 64'(e_pc));
      chk("instr", 64'(id_instr_out), 64'(e_in));
      if (tv_on) begin
         chk("vec_valid", 64'(id_valid_out), 64'(cur.ev));
         chk("vec_stall", 64'(stall_out), 64'(cur.es));
         if (cur.ev) begin
            chk("vec_pc", 64'(id_pc_out), 64'(cur.epc));
            chk("vec_instr", 64'(id_instr_out), 64'(imem(cur.epc)));
         end
      end
      s_v = id_valid_out; s_st = stall_out; s_pc = id_pc_out; s_in = id_instr_out;
      @(posedge clk);
      deq = e_v && rdy;
      acc = req && !e_st && !fl;
      enq = minf && !fl;
      if (fl) begin
         mq.delete();
         minf = 1'b0;
      end else begin
         if (deq) void'(mq.pop_front());
         if (enq) mq.push_back({mpc, imem_rdata_in});
         minf = acc;
         if (acc) mpc = pc;
      end
      prev_pc = pc;
      @(negedge clk);
   endtask

   task automatic model_clear();
      mq.delete();
      minf = 1'b0;
      mpc  = '0;
   endtask

   task automatic do_reset();
      req_valid_in = 1'b0; flush_in = 1'b0; id_ready_in = 1'b0; pc_in = '0;
      rst_n = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_valid", 64'(id_valid_out), 64'd0);
      chk("rst_stall", 64'(stall_out), 64'd0);
      chk("rst_pc", 64'(id_pc_out), 64'd0);
      chk("rst_instr", 64'(id_instr_out), 64'd0);
      rst_n = 1'b1;
      model_clear();
   endtask

   function automatic vec_t mkv(bit req, logic [31:0] pc, bit rdy, bit ev, bit es, logic [31:0] epc);
      vec_t v;
      v.req = req; v.pc = pc; v.rdy = rdy; v.ev = ev; v.es = es; v.epc = epc;
      return v;
   endfunction

   initial begin
      vec_t        tv[11];
      logic [31:0] p0, nextpc;
      logic [31:0] got[$];
      p0 = RESET_PC_VAL;
      prev_pc = '0;
      tv_on = 1'b0;
      model_clear();

      // backpressure then drain, hand-derived from the handshake rules
      tv[0]  = mkv(1, p0,      0, 0, 0, 0);
      tv[1]  = mkv(1, p0 + 4,  0, 0, 0, 0);
      tv[2]  = mkv(1, p0 + 8,  0, 1, 0, p0);
      tv[3]  = mkv(1, p0 + 12, 0, 1, 0, p0);
      tv[4]  = mkv(1, p0 + 16, 0, 1, 1, p0);
      tv[5]  = mkv(1, p0 + 16, 0, 1, 1, p0);
      tv[6]  = mkv(1, p0 + 16, 1, 1, 1, p0);
      tv[7]  = mkv(1, p0 + 16, 1, 1, 0, p0 + 4);
      tv[8]  = mkv(1, p0 + 20, 1, 1, 0, p0 + 8);
      tv[9]  = mkv(0, p0 + 20, 1, 1, 0, p0 + 12);
      tv[10] = mkv(0, 32'h0,   1, 1, 0, p0 + 16);

      @(negedge clk);

      // T1 reset
      do_reset();

      // T2 streaming
      for (int i = 0; i < 12; i++) begin
         step(1, p0 + 32'(4 * i), 0, 1);
         if (i == 2) begin
            chk("t2_first_valid", 64'(s_v), 64'd1);
            chk("t2_first_entry", {s_pc, s_in}, {p0, NOP_INSTR});
         end
         if (i >= 2) chk("t2_order", 64'(s_pc), 64'(p0 + 32'(4 * (i - 2))));
         chk("t2_no_stall", 64'(s_st), 64'd0);
      end

      // T3 backpressure via vector table
      do_reset();
      tv_on = 1'b1;
      for (int i = 0; i < 11; i++) begin
         cur = tv[i];
         step(cur.req, cur.pc, 0, cur.rdy);
      end
      tv_on = 1'b0;
      repeat (3) step(0, 0, 0, 1);
      chk("t3_drained", 64'(id_valid_out), 64'd0);

      // T4 flush with 2 queued + 1 in flight
      do_reset();
      step(1, p0,      0, 0);
      step(1, p0 + 4,  0, 0);
      step(1, p0 + 8,  0, 0);
      step(1, 32'h3000_0000, 1, 1);
      chk("t4_flush_cycle_valid", 64'(s_v), 64'd0);
      step(1, 32'h2000_0000, 0, 1);
      chk("t4_after_flush_valid", 64'(s_v), 64'd0);
      step(1, 32'h2000_0004, 0, 1);
      chk("t4_gap_valid", 64'(s_v), 64'd0);
      step(0, 32'h0, 0, 1);
      chk("t4_new_path", {32'(s_v), s_pc}, {32'd1, 32'h2000_0000});
      chk("t4_new_instr", 64'(s_in), 64'(imem(32'h2000_0000)));
      step(0, 32'h0, 0, 1);
      chk("t4_second", 64'(s_pc), 64'h2000_0004);

      // T5 wrap: random ready, IF holds PC while stalled
      do_reset();
      nextpc = p0;
      got.delete();
      for (int c = 0; c < 200 && got.size() < 12; c++) begin
         bit r, q;
         r = 1'($urandom_range(0, 1));
         q = (nextpc < p0 + 32'd48);
         step(q, nextpc, 0, r);
         if (q && !s_st) nextpc = nextpc + 4;
         if (s_v && r) got.push_back(s_pc);
      end
      chk("t5_count", 64'(got.size()), 64'd12);
      for (int i = 0; i < got.size(); i++)
         chk("t5_order", 64'(got[i]), 64'(p0 + 32'(4 * i)));

      // random traffic with flushes, model-checked
      do_reset();
      nextpc = p0;
      for (int c = 0; c < 300; c++) begin
         bit r, q, f;
         r = ($urandom_range(0, 3) != 0);
         q = ($urandom_range(0, 4) != 0);
         f = ($urandom_range(0, 19) == 0);
         step(q, nextpc, f, r);
         if (f) nextpc = p0 + 32'($urandom_range(0, 255) * 4);
         else if (q && !s_st) nextpc = nextpc + 4;
      end

      // T6 async reset mid-operation with 3 queued
      do_reset();
      for (int i = 0; i < 4; i++) step(1, p0 + 32'(4 * i), 0, 0);
      chk("t6_pre_valid", 64'(id_valid_out), 64'd1);
      req_valid_in = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 64'(id_valid_out), 64'd0);
      chk("t6_async_stall", 64'(stall_out), 64'd0);
      chk("t6_async_pc", 64'(id_pc_out), 64'd0);
      chk("t6_async_instr", 64'(id_instr_out), 64'd0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, p0, 0, 1);
      step(1, p0 + 4, 0, 1);
      step(0, 0, 0, 1);
      chk("t6_restart", {32'(s_v), s_pc}, {32'd1, p0});
      chk("t6_restart_instr", 64'(s_in), 64'(NOP_INSTR));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
